// File: rtl/reg_file_scoreboard.sv
// DEPTH x WIDTH register file: one write port, two registered bypassed read ports, busy scoreboard.
// Optional macro ZERO_REG_EN hardwires register 0 to zero and keeps it permanently not-busy.
module reg_file_scoreboard #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en1,
   input  logic [ADDR_W-1:0] rd_addr1,
   output logic [WIDTH-1:0]  rd_data1,
   input  logic              rd_en2,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [WIDTH-1:0]  rd_data2,
   input  logic              set_busy,
   input  logic [ADDR_W-1:0] set_addr,
   output logic              busy1,
   output logic              busy2,
   output logic [DEPTH-1:0]  busy_vec
);

`ifdef ZERO_REG_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif

   logic [WIDTH-1:0] regs [DEPTH];
   logic             wr_ok;
   logic             set_ok;
   logic [WIDTH-1:0] byp1;
   logic [WIDTH-1:0] byp2;

   // Register 0 never accepts writes or busy marks when hardwired, so its storage stays at reset 0.
   assign wr_ok  = wr_en    & ~(ZERO_REG & (wr_addr  == '0));
   assign set_ok = set_busy & ~(ZERO_REG & (set_addr == '0));

   assign byp1 = (wr_ok && (wr_addr == rd_addr1)) ? wr_data : regs[rd_addr1];
   assign byp2 = (wr_ok && (wr_addr == rd_addr2)) ? wr_data : regs[rd_addr2];

   // A register being written this cycle is reported ready, matching the bypass path.
   assign busy1 = busy_vec[rd_addr1] & ~(wr_en & (wr_addr == rd_addr1));
   assign busy2 = busy_vec[rd_addr2] & ~(wr_en & (wr_addr == rd_addr2));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Set has priority over the writeback clear: a new producer issued as the old one retires.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_vec <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (set_ok && (set_addr == ADDR_W'(i)))
               busy_vec[i] <= 1'b1;
            else if (wr_ok && (wr_addr == ADDR_W'(i)))
               busy_vec[i] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data1 <= '0;
         rd_data2 <= '0;
      end else begin
         if (rd_en1) rd_data1 <= byp1;
         if (rd_en2) rd_data2 <= byp2;
      end
   end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Self-checking bench for reg_file_scoreboard: directed scenarios then randomized traffic
// compared against an array-based reference model (honours ZERO_REG_EN when defined).
module tb_reg_file_scoreboard;

   localparam int WIDTH  = 16;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

`ifdef ZERO_REG_EN
   localparam bit ZR = 1'b1;
`else
   localparam bit ZR = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              rd_en1;
   logic [ADDR_W-1:0] rd_addr1;
   logic [WIDTH-1:0]  rd_data1;
   logic              rd_en2;
   logic [ADDR_W-1:0] rd_addr2;
   logic [WIDTH-1:0]  rd_data2;
   logic              set_busy;
   logic [ADDR_W-1:0] set_addr;
   logic              busy1;
   logic              busy2;
   logic [DEPTH-1:0]  busy_vec;

   always #5 clk = ~clk;

   reg_file_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(rd_data1),
      .rd_en2(rd_en2), .rd_addr2(rd_addr2), .rd_data2(rd_data2),
      .set_busy(set_busy), .set_addr(set_addr),
      .busy1(busy1), .busy2(busy2), .busy_vec(busy_vec)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int unsigned m_mem  [DEPTH];
   bit          m_busy [DEPTH];
   int unsigned m_rd1;
   int unsigned m_rd2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i]  = 0;
         m_busy[i] = 0;
      end
      m_rd1 = 0;
      m_rd2 = 0;
   endfunction

   function automatic int unsigned model_read(input int a);
      if (ZR && a == 0) return 0;
      if (wr_en && int'(wr_addr) == a) return int'(wr_data);
      return m_mem[a];
   endfunction

   function automatic bit model_busy_out(input int a);
      if (ZR && a == 0) return 1'b0;
      return m_busy[a] && !(wr_en && int'(wr_addr) == a);
   endfunction

   function automatic logic [DEPTH-1:0] model_busy_vec();
      logic [DEPTH-1:0] v;
      for (int i = 0; i < DEPTH; i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic drive(input bit we, input int wa, input int wd,
                        input bit r1, input int a1, input bit r2, input int a2,
                        input bit sb, input int sa);
      wr_en = we;  wr_addr = ADDR_W'(wa); wr_data = WIDTH'(wd);
      rd_en1 = r1; rd_addr1 = ADDR_W'(a1);
      rd_en2 = r2; rd_addr2 = ADDR_W'(a2);
      set_busy = sb; set_addr = ADDR_W'(sa);
   endtask

   // One clock: check combinational busy mid-cycle, advance model at the edge, check registers after.
   task automatic step(input string tag);
      @(negedge clk);
      chk({tag, ".busy1"}, 32'(busy1), 32'(model_busy_out(int'(rd_addr1))));
      chk({tag, ".busy2"}, 32'(busy2), 32'(model_busy_out(int'(rd_addr2))));
      @(posedge clk);
      if (rd_en1) m_rd1 = model_read(int'(rd_addr1));
      if (rd_en2) m_rd2 = model_read(int'(rd_addr2));
      if (wr_en && !(ZR && wr_addr == 0)) begin
         m_mem[wr_addr]  = int'(wr_data);
         m_busy[wr_addr] = 0;
      end
      if (set_busy && !(ZR && set_addr == 0)) m_busy[set_addr] = 1;
      #1;
      chk({tag, ".rd_data1"}, 32'(rd_data1), m_rd1);
      chk({tag, ".rd_data2"}, 32'(rd_data2), m_rd2);
      chk({tag, ".busy_vec"}, 32'(busy_vec), 32'(model_busy_vec()));
   endtask

   initial begin
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk); #1;
      chk("por.rd_data1", 32'(rd_data1), 32'h0);
      chk("por.busy_vec", 32'(busy_vec), 32'h0);

      // Load reg 2 and capture 0x1234, then assert reset mid-cycle
      drive(1, 2, 'h1234, 0, 0, 0, 0, 0, 0); step("ld2");
      drive(0, 0, 0, 1, 2, 0, 0, 1, 6);        step("rd2");
      chk("pre_rst.rd_data1", 32'(rd_data1), 32'h1234);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2 rst = 1'b0;
      #1;
      chk("async_rst.rd_data1", 32'(rd_data1), 32'h0);
      chk("async_rst.rd_data2", 32'(rd_data2), 32'h0);
      chk("async_rst.busy_vec", 32'(busy_vec), 32'h0);
      model_reset();
      @(posedge clk); #3 rst = 1'b1;

      drive(0, 0, 0, 1, 5, 1, 2, 0, 0);        step("rd5");
      chk("rd5.rd_data1", 32'(rd_data1), 32'h0000);
      chk("rd5.rd_data2", 32'(rd_data2), 32'h0000);

      // Write/read latency and stall hold
      drive(1, 3, 'hBEEF, 0, 0, 0, 0, 0, 0);   step("wr3");
      drive(0, 0, 0, 1, 3, 0, 0, 0, 0);        step("rd3");
      chk("rd3.rd_data1", 32'(rd_data1), 32'hBEEF);
      drive(1, 3, 'h1111, 0, 3, 0, 0, 0, 0);   step("hold1");
      drive(0, 0, 0, 0, 8, 0, 0, 0, 0);        step("hold2");
      chk("hold.rd_data1", 32'(rd_data1), 32'hBEEF);

      // Write-to-read bypass
      drive(1, 7, 'h0001, 0, 0, 0, 0, 0, 0);   step("wr7");
      drive(1, 7, 'hA5A5, 0, 0, 1, 7, 0, 0);   step("byp7");
      chk("byp7.rd_data2", 32'(rd_data2), 32'hA5A5);

      // Scoreboard set, then clear by writeback
      drive(0, 0, 0, 0, 4, 0, 0, 1, 4);        step("set4");
      drive(0, 0, 0, 0, 4, 0, 0, 0, 0);        step("chk4");
      chk("set4.busy1", 32'(busy1), 32'h1);
      chk("set4.busy_vec4", 32'(busy_vec[4]), 32'h1);
      drive(1, 4, 'h0042, 1, 4, 1, 4, 0, 0);
      #1 chk("wr4.busy1_during_write", 32'(busy1), 32'h0);
      step("wr4");
      chk("wr4.rd_data1", 32'(rd_data1), 32'h0042);
      chk("wr4.busy_vec4", 32'(busy_vec[4]), 32'h0);

      // Set/write collision on the same address: set wins, data stored
      drive(1, 9, 'h7777, 0, 0, 0, 0, 1, 9);   step("col9");
      chk("col9.busy_vec9", 32'(busy_vec[9]), 32'h1);
      drive(0, 0, 0, 1, 9, 0, 0, 0, 0);        step("rd9");
      chk("col9.rd_data1", 32'(rd_data1), 32'h7777);

      // Set and write on different addresses in the same cycle
      drive(1, 10, 'h0A0A, 0, 0, 0, 0, 1, 11); step("setwr");
      chk("setwr.busy_vec11", 32'(busy_vec[11]), 32'h1);

      // Register 0 behaviour depends on ZERO_REG_EN
      drive(1, 0, 'hFFFF, 0, 0, 0, 0, 1, 0);   step("wr0");
      drive(0, 0, 0, 1, 0, 1, 0, 0, 0);        step("rd0");
      chk("r0.rd_data1", 32'(rd_data1), ZR ? 32'h0000 : 32'hFFFF);
      chk("r0.rd_data2", 32'(rd_data2), ZR ? 32'h0000 : 32'hFFFF);
      chk("r0.busy_vec0", 32'(busy_vec[0]), ZR ? 32'h0 : 32'h1);
      chk("r0.busy1", 32'(busy1), ZR ? 32'h0 : 32'h1);
      drive(1, 0, 'h5A5A, 0, 0, 1, 0, 0, 0);   step("byp0");
      chk("r0.bypass", 32'(rd_data2), ZR ? 32'h0000 : 32'h5A5A);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 99) < 50, $urandom_range(0, DEPTH - 1), $urandom_range(0, 65535),
               $urandom_range(0, 99) < 70, $urandom_range(0, DEPTH - 1),
               $urandom_range(0, 99) < 70, $urandom_range(0, DEPTH - 1),
               $urandom_range(0, 99) < 30, $urandom_range(0, DEPTH - 1));
         if ($urandom_range(0, 3) == 0) rd_addr2 = rd_addr1;
         if ($urandom_range(0, 3) == 0) set_addr = wr_addr;
         step("rand");
      end

      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
- Parametrised successor to the 16-bit two-read-port register.
- Holds DEPTH registers of WIDTH bits.
- Provides one synchronous write port and two registered read ports with write-to-read bypass.
- A per-register busy scoreboard lets the decode stage detect operands still pending from an in-flight producer.
- Sits between decode (reads, busy checks) and writeback (writes) in the CPU pipeline.

Parameters:
WIDTH, 16, data bits per register
DEPTH, 16, number of registers; must be a power of two >= 2
ADDR_W, $clog2(DEPTH), address width (derived; not to be overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
wr_en  input  1  write strobe
wr_addr  input  ADDR_W  write address
wr_data  input  WIDTH  write data
rd_en1  input  1  read port 1 capture enable
rd_addr1  input  ADDR_W  read port 1 address
rd_data1  output  WIDTH  read port 1 data, registered
rd_en2  input  1  read port 2 capture enable
rd_addr2  input  ADDR_W  read port 2 address
rd_data2  output  WIDTH  read port 2 data, registered
set_busy  input  1  mark a register as pending
set_addr  input  ADDR_W  register to mark pending
busy1  output  1  operand at rd_addr1 is pending (combinational)
busy2  output  1  operand at rd_addr2 is pending (combinational)
busy_vec  output  DEPTH  raw scoreboard state

Behaviour:
- Reset (rst=0, asynchronous): all registers, busy_vec, rd_data1 and rd_data2 go to 0 immediately. They stay 0 until the first clk edge after rst returns high.
- Write: at posedge with wr_en=1, reg[wr_addr] <= wr_data, and busy[wr_addr] is cleared.
- Read:
  - At posedge with rd_enN=1, rd_dataN <= bypassed value of rd_addrN. Latency is 1 cycle; the value appears the cycle after the address is presented.
  - Bypassed value: wr_data when wr_en=1 and wr_addr==rd_addrN; otherwise reg[rd_addrN].
  - With rd_enN=0, rd_dataN holds its previous value. This is the stall hold.
  - Both ports may read the same address in the same cycle; both receive the same value.
- Scoreboard set/clear:
  - At posedge with set_busy=1, busy[set_addr] <= 1.
  - Simultaneous set_busy and wr_en to the same address: set wins, so busy stays 1. The write data is still stored (old producer retires, new one issues).
  - Simultaneous set and write to different addresses: both take effect.
- busyN outputs:
  - busyN = busy[rd_addrN] & ~(wr_en & wr_addr==rd_addrN). A register being written this cycle therefore reports not-busy, consistent with the bypass.
  - A set_busy in the same cycle does not affect busyN until the next cycle.
- Reading a busy register with rd_enN=1 still captures the stored value. Consumers must gate on busyN; the block never stalls on its own.
- Addresses are always in range, since DEPTH is a power of two.
- No X propagation: every register has a reset value.

Optional Feature:
Macro ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to 0; writes to address 0 are discarded.
  - set_busy to address 0 is ignored, so busy_vec[0] is always 0.
  - Bypass is suppressed for address 0, so reads of address 0 always return 0.
  - busyN is 0 whenever rd_addrN==0.
- Not defined: register 0 behaves like every other register.

Test Plan:
- Reset then read: rst low mid-run with rd_data1=0x1234 -> rd_data1, rd_data2 and busy_vec are 0 before the next clk edge. After release, reading address 5 returns 0x0000.
- Write/read latency: write 0xBEEF to reg 3; next cycle rd_en1=1, rd_addr1=3 -> rd_data1=0xBEEF one cycle later. rd_en1=0 on the following cycles -> rd_data1 holds 0xBEEF.
- Bypass: same cycle wr_en=1, wr_addr=7, wr_data=0xA5A5, rd_en2=1, rd_addr2=7 (reg 7 previously 0x0001) -> rd_data2=0xA5A5 next cycle.
- Scoreboard:
  - set_busy to reg 4 -> busy1=1 with rd_addr1=4 next cycle, and busy_vec[4]=1.
  - Write reg 4 with 0x0042 -> busy1=0 during the write cycle; rd_data1=0x0042 after capture.
- Set/write collision: set_busy=1, set_addr=9, wr_en=1, wr_addr=9, wr_data=0x7777 same cycle -> busy_vec[9]=1, and a later read of 9 returns 0x7777.
- ZERO_REG_EN defined: write 0xFFFF to reg 0 with set_busy to reg 0 -> reads return 0x0000, and busy1=0 / busy_vec[0]=0. Without the macro -> reads return 0xFFFF and busy_vec[0]=1.
